uart_tx_ctrl_fsm: RTL
=====================

// Module: uart_tx_ctrl_fsm
// PURPOSE
//  Frame sequencer for the UART transmitter. Accepts a data-valid request, then drives the
//  serializer (load/shift) and the TX output mux select through START, DATA, optional PARITY
//  and STOP slots. Sits between the TX register interface and the serializer, parity calc and
//  registered 4:1 TX mux; owns all TX frame timing.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (>=2); sets DATA slot length and bit-counter width
// PORTS
//  CLK_fsm         in   1  system clock, rising edge
//  RST_fsm         in   1  reset, asynchronous, active-high
//  data_valid_fsm  in   1  frame request; data sampled by serializer on ser_load_fsm
//  par_en_fsm      in   1  parity slot enable; latched on accept
//  ser_load_fsm    out  1  1-cycle pulse: serializer + parity calc capture parallel data
//  ser_en_fsm      out  1  serializer shift enable, high every DATA cycle
//  mux_sel_fsm     out  2  TX mux select: 00 start, 01 stop/idle, 10 serial data, 11 parity
//  data_ack_fsm    out  1  1-cycle pulse, request accepted (same cycle as ser_load_fsm)
//  busy_fsm        out  1  high while a frame is in START..STOP
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, bit_cnt=0, par_en_q=0; mux_sel=01, all others 0.
//  - Moore outputs decoded from state; accept pulses decoded from state & data_valid.
//  - States: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   mux_sel=01. data_valid=1 -> ser_load=1, data_ack=1, par_en_q<=par_en -> START.
//    START:  mux_sel=00, busy=1, 1 cycle -> DATA; bit_cnt<=0.
//    DATA:   mux_sel=10, ser_en=1, busy=1; bit_cnt++ each cycle; at bit_cnt==DATA_WIDTH-1
//            -> PARITY if par_en_q else STOP. Exactly DATA_WIDTH cycles, LSB first.
//    PARITY: mux_sel=11, busy=1, 1 cycle -> STOP.
//    STOP:   mux_sel=01, busy=1, 1 cycle. data_valid=1 -> ser_load, data_ack, relatch
//            par_en -> START (back-to-back, no idle gap); else -> IDLE.
//  - data_valid ignored (no ack, no load) in START, DATA, PARITY.
//  - par_en changes after accept have no effect on the current frame.
//  - bit_cnt width $clog2(DATA_WIDTH); never wraps (state exits at DATA_WIDTH-1).
//  - Latency: accept at cycle 0 -> START select at cycle 1; TX line lags select by one
//    cycle (registered mux). Frame = 1+DATA_WIDTH+par+1 cycles of busy.
//  - Reset mid-frame: frame aborted, mux_sel=01 at once, no pulse on release; next frame
//    starts only on a new data_valid in IDLE.
//  - Illegal/unused state encodings recover to IDLE on next clock.
// STRUCTURE
//  - Shared package uart_tx_pkg: state encodings, MUX_SEL_START/STOP/DATA/PAR constants
//    (also used by the mux and testbench).
//  - No sub-module: single state register + bit counter + output decode, inline.
// TESTING
//  1. RST_fsm=1 pulsed mid-DATA (bit 3) -> same cycle: mux_sel=01, busy=0, ser_en=0;
//     after release no ack without new data_valid.
//  2. DATA_WIDTH=8, par_en=0, data_valid 1 cycle at c0 -> ack/load at c0; mux_sel 00 @c1,
//     10 @c2..c9 (8 ser_en pulses), 01 @c10; busy c1..c10; IDLE @c11.
//  3. par_en=1 -> mux_sel 11 @c10, 01 @c11; busy c1..c11 (11 cycles).
//  4. data_valid held high, par_en=0 -> 2nd ack/load @c10 (STOP), START @c11, continuous
//     busy; no ack during c1..c9.
//  5. par_en=1 at accept, dropped to 0 @c4 -> PARITY slot still present @c10.
//  6. DATA_WIDTH=5, par_en=1 -> exactly 5 ser_en cycles c2..c6, 11 @c7, 01 @c8.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// UART TX shared definitions: frame sequencer states
// and TX output mux select codes.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_SEL_START = 2'b00;
  localparam logic [1:0] MUX_SEL_STOP  = 2'b01;
  localparam logic [1:0] MUX_SEL_DATA  = 2'b10;
  localparam logic [1:0] MUX_SEL_PAR   = 2'b11;

  // TX mux select driven while in a given state
  function automatic logic [1:0] sel_for(
    input tx_state_e s
  );
    logic [1:0] sel;
    sel = MUX_SEL_STOP;
    case (s)
      ST_START:  sel = MUX_SEL_START;
      ST_DATA:   sel = MUX_SEL_DATA;
      ST_PARITY: sel = MUX_SEL_PAR;
      default:   sel = MUX_SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_fsm.sv
// UART TX frame sequencer: START, DATA, optional
// PARITY and STOP slots; drives serializer and TX mux.
module uart_tx_ctrl_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK_fsm,
  input  logic       RST_fsm,
  input  logic       data_valid_fsm,
  input  logic       par_en_fsm,
  output logic       ser_load_fsm,
  output logic       ser_en_fsm,
  output logic [1:0] mux_sel_fsm,
  output logic       data_ack_fsm,
  output logic       busy_fsm
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             par_en_q;
  logic             accept;
  logic [1:0]       mux_sel_q;
  logic             busy_q;
  logic             ser_en_q;

  // Requests are taken only in IDLE or STOP, never in reset
  always_comb begin
    accept = ~RST_fsm & data_valid_fsm &
             ((state_q == ST_IDLE) |
              (state_q == ST_STOP));
  end

  // Next-state decode; unused encodings fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = accept ? ST_START : ST_IDLE;
      ST_START:  state_d = ST_DATA;
      ST_DATA: begin
        if (bit_cnt_q == CNT_LAST)
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        else
          state_d = ST_DATA;
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, bit counter, parity latch and registered
  // Moore outputs (decoded from the state being entered)
  always_ff @(posedge CLK_fsm or posedge RST_fsm) begin
    if (RST_fsm) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      mux_sel_q <= MUX_SEL_STOP;
      busy_q    <= 1'b0;
      ser_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        par_en_q <= par_en_fsm;
      if (state_q == ST_DATA && bit_cnt_q != CNT_LAST)
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      else
        bit_cnt_q <= '0;
      mux_sel_q <= sel_for(state_d);
      busy_q    <= (state_d != ST_IDLE);
      ser_en_q  <= (state_d == ST_DATA);
    end
  end

  assign ser_load_fsm = accept;
  assign data_ack_fsm = accept;
  assign ser_en_fsm   = ser_en_q;
  assign mux_sel_fsm  = mux_sel_q;
  assign busy_fsm     = busy_q;

endmodule
